// File: rtl/mmu_cmpl_router_if.sv
// rtl/mmu_cmpl_router_if.sv - ordering-entry, dma-done and per-region completion bundle
// Purpose: groups every handshake/status signal of mmu_cmpl_router.
//   master: the side feeding ordering entries and done pulses and consuming completions
//   slave : the router itself
// Signals:
//   s_mux_valid/ready/vfid/pid/dest/last  ordering entry channel (one per XDMA chunk)
//   dma_done                              one-cycle pulse per completed chunk
//   m_done_valid/ready/pid/dest           per-region completion channels (slice i = region i)
//   outstanding                           entries held in the ordering FIFO
//   err_underflow, err_timeout            sticky error flags
interface mmu_cmpl_router_if #(
    parameter int N_REGIONS     = 4,
    parameter int N_OUTSTANDING = 16,
    parameter int PID_BITS      = 6,
    parameter int DEST_BITS     = 4
);
    localparam int RID_BITS = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam int CNT_BITS = $clog2(N_OUTSTANDING) + 1;

    logic                           s_mux_valid;
    logic                           s_mux_ready;
    logic [RID_BITS-1:0]            s_mux_vfid;
    logic [PID_BITS-1:0]            s_mux_pid;
    logic [DEST_BITS-1:0]           s_mux_dest;
    logic                           s_mux_last;
    logic                           dma_done;
    logic [N_REGIONS-1:0]           m_done_valid;
    logic [N_REGIONS-1:0]           m_done_ready;
    logic [N_REGIONS*PID_BITS-1:0]  m_done_pid;
    logic [N_REGIONS*DEST_BITS-1:0] m_done_dest;
    logic [CNT_BITS-1:0]            outstanding;
    logic                           err_underflow;
    logic                           err_timeout;

    modport master (
        output s_mux_valid, s_mux_vfid, s_mux_pid, s_mux_dest, s_mux_last,
        output dma_done, m_done_ready,
        input  s_mux_ready, m_done_valid, m_done_pid, m_done_dest,
        input  outstanding, err_underflow, err_timeout
    );

    modport slave (
        input  s_mux_valid, s_mux_vfid, s_mux_pid, s_mux_dest, s_mux_last,
        input  dma_done, m_done_ready,
        output s_mux_ready, m_done_valid, m_done_pid, m_done_dest,
        output outstanding, err_underflow, err_timeout
    );
endinterface

// File: rtl/mmu_cmpl_router.sv
// rtl/mmu_cmpl_router.sv - matches XDMA done pulses to ordering entries and routes completions
// Purpose: an ordering FIFO records one entry per issued chunk; each dma_done pulse
//   retires the head entry in issue order, and the entry flagged last produces a
//   (pid, dest) completion in the owning region's one-entry output slot.
// Ports:
//   aclk, areset : clock, asynchronous active-high reset
//   bus          : mmu_cmpl_router_if.slave (ordering entries, dma_done, completions, status)
// Optional feature: define MMU_CMPL_TIMEOUT_EN to build the stuck-FIFO watchdog
//   driving err_timeout; otherwise err_timeout is tied low.
module mmu_cmpl_router #(
    parameter int N_REGIONS      = 4,
    parameter int N_OUTSTANDING  = 16,
    parameter int PID_BITS       = 6,
    parameter int DEST_BITS      = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic             aclk,
    input  logic             areset,
    mmu_cmpl_router_if.slave bus
);
    localparam int RID_BITS = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam int PTR_BITS = $clog2(N_OUTSTANDING);
    localparam int CNT_BITS = PTR_BITS + 1;

    typedef struct packed {
        logic [RID_BITS-1:0]  vfid;
        logic [PID_BITS-1:0]  pid;
        logic [DEST_BITS-1:0] dest;
        logic                 last;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_POP, S_BLOCK} state_t;

    entry_t               fifo_mem [N_OUTSTANDING];
    logic [PTR_BITS-1:0]  wr_ptr, rd_ptr;
    logic [CNT_BITS-1:0]  count, pend;
    state_t               state;
    entry_t               hold;
    logic [N_REGIONS-1:0] slot_valid;
    logic [PID_BITS-1:0]  slot_pid  [N_REGIONS];
    logic [DEST_BITS-1:0] slot_dest [N_REGIONS];
    logic                 err_underflow_q;

    logic full, push, pop, done_acc, vfid_ok, tgt_free, load_en;

    assign full     = (count == CNT_BITS'(N_OUTSTANDING));
    assign push     = bus.s_mux_valid && !full;
    // A done only matches if an entry exists that no earlier done has claimed.
    // Comparing registered pend/count keeps this exact across a same-cycle pop,
    // since the pop lowers both by one.
    assign done_acc = bus.dma_done && (pend < count);
    assign pop      = (state == S_IDLE) && (pend != '0) && (count != '0);

    // Target slot lookup without out-of-range indexing; an unknown vfid is
    // treated as a discard so it can never wedge the FSM.
    always_comb begin
        vfid_ok  = 1'b0;
        tgt_free = 1'b0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (hold.vfid == RID_BITS'(i)) begin
                vfid_ok  = 1'b1;
                tgt_free = !slot_valid[i] || bus.m_done_ready[i];
            end
        end
    end

    assign load_en = vfid_ok && tgt_free &&
                     (((state == S_POP) && hold.last) || (state == S_BLOCK));

    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{vfid: bus.s_mux_vfid, pid: bus.s_mux_pid,
                                  dest: bus.s_mux_dest, last: bus.s_mux_last};
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            pend            <= '0;
            state           <= S_IDLE;
            hold            <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);

            case ({push, pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: ;
            endcase

            case ({done_acc, pop})
                2'b10:   pend <= pend + CNT_BITS'(1);
                2'b01:   pend <= pend - CNT_BITS'(1);
                default: ;
            endcase

            if (bus.dma_done && !done_acc) err_underflow_q <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        hold  <= fifo_mem[rd_ptr];
                        state <= S_POP;
                    end
                end
                S_POP: begin
                    if (!hold.last || !vfid_ok || tgt_free) state <= S_IDLE;
                    else                                    state <= S_BLOCK;
                end
                S_BLOCK: begin
                    if (!vfid_ok || tgt_free) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Load wins over drain so a draining slot can be refilled in the same cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            slot_valid <= '0;
            for (int i = 0; i < N_REGIONS; i++) begin
                slot_pid[i]  <= '0;
                slot_dest[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REGIONS; i++) begin
                if (load_en && (hold.vfid == RID_BITS'(i))) begin
                    slot_valid[i] <= 1'b1;
                    slot_pid[i]   <= hold.pid;
                    slot_dest[i]  <= hold.dest;
                end else if (slot_valid[i] && bus.m_done_ready[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_REGIONS; g++) begin : g_out
            assign bus.m_done_pid[g*PID_BITS +: PID_BITS]    = slot_pid[g];
            assign bus.m_done_dest[g*DEST_BITS +: DEST_BITS] = slot_dest[g];
        end
    endgenerate

    assign bus.m_done_valid  = slot_valid;
    assign bus.s_mux_ready   = !full;
    assign bus.outstanding   = count;
    assign bus.err_underflow = err_underflow_q;

`ifdef MMU_CMPL_TIMEOUT_EN
    localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_BITS-1:0] tmo_cnt;
    logic                tmo_err;

    // Counts cycles with entries waiting but no done progress; saturates at the limit.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
        end else if (done_acc || (count == '0)) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_BITS'(TIMEOUT_CYCLES)) begin
            tmo_cnt <= tmo_cnt + TMO_BITS'(1);
            if (tmo_cnt == TMO_BITS'(TIMEOUT_CYCLES - 1)) tmo_err <= 1'b1;
        end
    end

    assign bus.err_timeout = tmo_err;
`else
    logic unused_timeout;
    assign unused_timeout  = (TIMEOUT_CYCLES == 0);
    assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: doc/mmu_cmpl_router.md
Name: mmu_cmpl_router

Overview:
- Return-path counterpart of the host-DMA request arbiter.
- The arbiter records one ordering entry per issued XDMA chunk; the XDMA engine pulses done per chunk, in issue order.
- This block matches each done pulse to its ordering entry and routes a completion (pid, dest) to the owning region's config slave.
- Completion is emitted only on a request's last chunk. One instance per direction (rd, wr).

Parameters:
- N_REGIONS, 4, number of vFPGA regions; RID_BITS = max(1, $clog2(N_REGIONS)).
- N_OUTSTANDING, 16, ordering FIFO depth; power of 2, >= 2.
- PID_BITS, 6, process id width.
- DEST_BITS, 4, destination stream id width.
- TIMEOUT_CYCLES, 65536, watchdog limit; used only with MMU_CMPL_TIMEOUT_EN.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- s_mux_valid  in  1  ordering entry valid
- s_mux_ready  out  1  ordering entry accepted
- s_mux_vfid  in  RID_BITS  owning region
- s_mux_pid  in  PID_BITS  process id
- s_mux_dest  in  DEST_BITS  destination stream
- s_mux_last  in  1  last chunk of request
- dma_done  in  1  one-cycle pulse per completed XDMA chunk
- m_done_valid  out  N_REGIONS  per-region completion valid
- m_done_ready  in  N_REGIONS  per-region completion ready
- m_done_pid  out  N_REGIONS*PID_BITS  per-region pid, slice i for region i
- m_done_dest  out  N_REGIONS*DEST_BITS  per-region dest
- outstanding  out  $clog2(N_OUTSTANDING)+1  entries in FIFO
- err_underflow  out  1  sticky: done pulse with no matching entry
- err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset values:
  - All outputs 0, except s_mux_ready = 1.
  - FIFO empty, pending counter 0, FSM in IDLE, all region slots empty.
  - Reset asserted mid-operation discards all entries, pending dones and slot contents. No completion is emitted for them.
- Ordering FIFO:
  - s_mux_ready = !full.
  - Push on s_mux_valid && s_mux_ready; full is not bypassed by a same-cycle pop.
  - Pointers wrap modulo N_OUTSTANDING; count is tracked separately.
- Pending counter pend (width of outstanding):
  - +1 on an accepted dma_done; -1 on FSM pop; both in the same cycle leave it unchanged.
  - A dma_done arriving when pend == count (including from its own pop correction) has no matching entry: the pulse is dropped and err_underflow is set.
- FSM:
  - IDLE: if pend > 0 and FIFO not empty, register head into hold and pop → POP.
  - POP, !hold.last: discard hold → IDLE.
  - POP, hold.last, slot[vfid] empty or draining this cycle (valid && ready): load slot → IDLE.
  - POP, otherwise → BLOCK.
  - BLOCK: wait for slot[vfid] to be empty or draining, load it → IDLE.
  - While in BLOCK, later dones accumulate in pend. Routing stays strictly in order: a blocked region stalls all regions (head-of-line blocking is intended).
- Region slot i:
  - One-entry register; m_done_valid[i] stays high until m_done_ready[i].
  - pid/dest are stable while valid.
  - Load and drain in the same cycle are allowed, giving back-to-back completions.
- Latency: with dma_done sampled at cycle N and a free slot, pend = 1 at N+1, POP at N+2, m_done_valid high at N+3.
- Throughput: one entry per 2 cycles (IDLE/POP).

Optional Feature:
- Macro: MMU_CMPL_TIMEOUT_EN.
- With the macro defined:
  - A counter resets on every accepted dma_done and whenever the FIFO is empty.
  - It increments while the FIFO is not empty.
  - On reaching TIMEOUT_CYCLES it sets err_timeout (sticky until areset) and saturates.
- Without the macro: no counter is built, err_timeout is tied 0, and TIMEOUT_CYCLES is unused.

Test Plan:
- Push {vfid=2, pid=5, dest=1, last=1}, pulse dma_done at cycle 10 → m_done_valid = 4'b0100 at cycle 13, m_done_pid slice 2 = 5, dest = 1; outstanding 1→0.
- Push 3 entries for vfid 0 with last = 0,0,1 plus 3 dma_done pulses → exactly one completion on region 0, with pid of the third entry.
- Hold m_done_ready[1] = 0, queue two last entries for vfid 1 then one for vfid 3, pulse 3 dones → one region-1 completion pending, FSM in BLOCK, region 3 silent. Release ready → remaining region-1 completion, then region 3, in order.
- Push 16 entries with no dones → s_mux_ready = 0, outstanding = 16. A 17th valid is not accepted; one done+pop → ready returns 1.
- dma_done with FIFO empty → err_underflow = 1, no m_done_valid, pend stays 0. Assert areset mid-BLOCK → all valids 0 and err_underflow 0 immediately.
- With MMU_CMPL_TIMEOUT_EN and TIMEOUT_CYCLES = 100, one entry pushed and no done → err_timeout = 1 at cycle 100 after push. Without the macro → err_timeout stays 0.
